// File: rtl/fetch_queue.sv
// Instruction prefetch queue between IF and ID: a circular buffer of {PC, instruction}
// pairs, presented oldest-first with one cycle of latency, fully drained on flush.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_instr,
    output logic                     full,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // A full queue refuses the push even when a pop frees a slot the same cycle.
    assign push = in_valid & ~full;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            pc_mem[tail]    <= in_pc;
            instr_mem[tail] <= in_instr;
        end
    end

    assign out_pc    = out_valid ? pc_mem[head]    : '0;
    assign out_instr = out_valid ? instr_mem[head] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue tracks expected contents and every
// cycle the DUT's occupancy, flags and head entry are compared against it.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_instr;
    logic             full;
    logic             out_valid;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;
    logic             out_ready;
    logic [2:0]       count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [63:0] sb[$];

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .full      (full),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] instr_of(input logic [WIDTH-1:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] pc, input logic rdy,
                         input logic fl, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = rdy;
        flush     = fl;
        rst       = r;
    endtask

    // Advance one clock: update the reference from the inputs held across the edge,
    // then compare the DUT against it shortly after the edge.
    task automatic cycle();
        bit push_m, pop_m;
        @(posedge clk);
        push_m = in_valid && (sb.size() != DEPTH);
        pop_m  = out_ready && (sb.size() != 0);
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (pop_m)  void'(sb.pop_front());
            if (push_m) sb.push_back({in_pc, instr_of(in_pc)});
        end
        #1;
        check("count", 64'(count), 64'(sb.size()));
        check("full", 64'(full), 64'(sb.size() == DEPTH));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) check("head", {out_pc, out_instr}, sb[0]);
        else                check("bubble", {out_pc, out_instr}, 64'd0);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        // 1: reset
        repeat (2) cycle();
        check("rst_count", 64'(count), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);

        // 2: fill with ID stalled
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, WIDTH'(4 * i), 1'b0, 1'b0, 1'b0);
            cycle();
            check("fill_count", 64'(count), 64'(i));
            check("fill_head", 64'(out_pc), 64'd4);
        end
        check("fill_full", 64'(full), 64'd1);

        // 3: push while full and popping is dropped; then re-presented
        drive(1'b1, 32'd20, 1'b1, 1'b0, 1'b0);
        cycle();
        check("fullpop_count", 64'(count), 64'd3);
        check("fullpop_head", 64'(out_pc), 64'd8);
        drive(1'b1, 32'd20, 1'b0, 1'b0, 1'b0);
        cycle();
        check("repush_count", 64'(count), 64'd4);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle();
        check("drained", 64'(count), 64'd0);

        // 4: steady push+pop across pointer wrap
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, WIDTH'(4 * i), 1'b1, 1'b0, 1'b0);
            cycle();
            check("steady_pc", 64'(out_pc), 64'(4 * i));
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle();

        // 5: flush beats concurrent push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, WIDTH'(200 + 4 * i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'd300, 1'b1, 1'b1, 1'b0);
        cycle();
        check("flush_instr", 64'(out_instr), 64'd0);
        drive(1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
        cycle();
        check("post_flush_pc", 64'(out_pc), 64'd100);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle();

        // 6: reset mid-operation, then pops on an empty queue
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, WIDTH'(400 + 4 * i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'd500, 1'b0, 1'b1, 1'b1);
        cycle();
        check("rst_mid_out", {out_pc, out_instr}, 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle();
        check("empty_pop_count", 64'(count), 64'd0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), WIDTH'(1000 + 4 * i), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), 1'b0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
